register_file: RTL and testbench

- 8-entry x 32-bit general-purpose register file for the CPU datapath.
- Two combinational read ports and one clocked write port.
- Dedicated stack-pointer read/write port aliased onto register 4.
- All eight registers exported as flat debug outputs for display/monitor logic.

---
 rtl/register_file.sv | 78 +++++++
 tb/tb_register_file.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 8 x WIDTH general-purpose register file for the CPU datapath.
// Two combinational read ports, one clocked general write port, and a
// dedicated stack-pointer port aliased onto register SP_INDEX. Every register
// is also exported as a flat output for display/monitor logic.
//
// Write handshake: a write is a single-cycle request qualified by its enable
// (we or wesp) sampled at the rising edge of clk; there is no back-pressure,
// so every enabled write is accepted at that edge. Data and address are
// ignored while the enable is low.
module register_file #(
    parameter int                WIDTH    = 32,
    parameter int                SP_INDEX = 4,
    parameter logic [WIDTH-1:0]  SP_RESET = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       ra1,
    input  logic [2:0]       ra2,
    input  logic [2:0]       wa,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] wd,
    input  logic             we,
    output logic [WIDTH-1:0] rdsp,
    input  logic [WIDTH-1:0] wdsp,
    input  logic             wesp,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7
);

    localparam logic [2:0] SP_ADDR = SP_INDEX[2:0];

    logic [WIDTH-1:0] regs [8];

    // Storage update: reset dominates; the SP port is applied after the
    // general port so that it wins when both target SP_ADDR.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            if (we) begin
                regs[wa] <= wd;
            end
            if (wesp) begin
                regs[SP_ADDR] <= wdsp;
            end
        end
    end

    // Read ports: no write-through bypass, so a same-cycle read of the
    // address being written returns the stored (old) value.
    always_comb begin
        rd1  = regs[ra1];
        rd2  = regs[ra2];
        rdsp = regs[SP_ADDR];
    end

    // Flat debug view of the whole file.
    always_comb begin
        r0 = regs[0];
        r1 = regs[1];
        r2 = regs[2];
        r3 = regs[3];
        r4 = regs[4];
        r5 = regs[5];
        r6 = regs[6];
        r7 = regs[7];
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed test of register_file with hand-computed values
// plus a small reference model of the register contents.
module tb_register_file;

    localparam int W = 32;

    logic         clk;
    logic         n_rst;
    logic [2:0]   ra1, ra2, wa;
    logic [W-1:0] rd1, rd2, wd, rdsp, wdsp;
    logic         we, wesp;
    logic [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7;

    int checks;
    int failures;

    logic [W-1:0] mdl [8];
    logic [W-1:0] exp_q [$];

    register_file #(.WIDTH(W), .SP_INDEX(4), .SP_RESET('0)) dut (
        .clk (clk),  .n_rst(n_rst),
        .ra1 (ra1),  .ra2  (ra2),  .wa (wa),
        .rd1 (rd1),  .rd2  (rd2),  .wd (wd),  .we (we),
        .rdsp(rdsp), .wdsp (wdsp), .wesp(wesp),
        .r0  (r0),   .r1   (r1),   .r2 (r2),  .r3 (r3),
        .r4  (r4),   .r5   (r5),   .r6 (r6),  .r7 (r7)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] get_r(input int idx);
        case (idx)
            0: return r0;
            1: return r1;
            2: return r2;
            3: return r3;
            4: return r4;
            5: return r5;
            6: return r6;
            default: return r7;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One rising edge; the model takes the inputs as they stand at the edge.
    task automatic tick();
        @(posedge clk);
        if (n_rst) begin
            for (int i = 0; i < 8; i++) mdl[i] = '0;
        end else begin
            if (we)   mdl[wa] = wd;
            if (wesp) mdl[4]  = wdsp;
        end
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wesp = 1'b0; wa = '0; wd = '0; wdsp = '0;
    endtask

    task automatic drive_write(input logic [2:0] a, input logic [W-1:0] d);
        we = 1'b1; wa = a; wd = d;
    endtask

    task automatic drive_sp(input logic [W-1:0] d);
        wesp = 1'b1; wdsp = d;
    endtask

    // Scoreboard: queue expected read data from the model, then pop and compare.
    task automatic check_reads(input string tag);
        exp_q.push_back(mdl[ra1]);
        exp_q.push_back(mdl[ra2]);
        check({tag, "_rd1"}, rd1, exp_q.pop_front());
        check({tag, "_rd2"}, rd2, exp_q.pop_front());
    endtask

    task automatic check_file(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_r%0d", tag, i), get_r(i), mdl[i]);
        end
        check({tag, "_rdsp"}, rdsp, mdl[4]);
    endtask

    logic [2:0]   vec_a [3];
    logic [W-1:0] vec_d [3];

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 8; i++) mdl[i] = 'x;
        idle();
        ra1 = 3'd0; ra2 = 3'd7;
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        #1;

        // Reset state
        for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), get_r(i), 32'h0);
        check("reset_rdsp", rdsp, 32'h0);
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);

        // Write then read back; old value before the edge, new value after
        vec_a[0] = 3'd3; vec_d[0] = 32'hAAAAAAAA;
        vec_a[1] = 3'd4; vec_d[1] = 32'h55555555;
        vec_a[2] = 3'd5; vec_d[2] = 32'h12345678;
        for (int v = 0; v < 3; v++) begin
            drive_write(vec_a[v], vec_d[v]);
            ra1 = vec_a[v]; ra2 = vec_a[v];
            #1;
            check($sformatf("wr%0d_old_rd1", v), rd1, 32'h0);
            check($sformatf("wr%0d_old_rd2", v), rd2, 32'h0);
            tick();
            check($sformatf("wr%0d_new_rd1", v), rd1, vec_d[v]);
            check($sformatf("wr%0d_new_rd2", v), rd2, vec_d[v]);
        end
        idle();
        #1;
        check("wr_r3", r3, 32'hAAAAAAAA);
        check("wr_r4", r4, 32'h55555555);
        check("wr_r5", r5, 32'h12345678);
        check("wr_rdsp", rdsp, 32'h55555555);
        check_file("wr_file");

        // Same-cycle read of the address being written
        ra1 = 3'd3; ra2 = 3'd3;
        drive_write(3'd3, 32'h0F0F0F0F);
        #1;
        check("same_old_rd1", rd1, 32'hAAAAAAAA);
        check("same_old_rd2", rd2, 32'hAAAAAAAA);
        tick();
        check("same_new_rd1", rd1, 32'h0F0F0F0F);
        check("same_new_rd2", rd2, 32'h0F0F0F0F);
        idle();

        // Write disabled: nothing changes, including with an unknown address
        we = 1'b0; wa = 3'd1; wd = 32'h11122111;
        for (int k = 0; k < 4; k++) tick();
        wa = 3'bxxx;
        tick();
        check("wdis_r1", r1, 32'h0);
        check("wdis_r3", r3, 32'h0F0F0F0F);
        check_file("wdis_file");
        idle();

        // Register 0 is an ordinary register
        drive_write(3'd0, 32'hCAFEF00D);
        ra1 = 3'd0; ra2 = 3'd5;
        tick();
        idle();
        #1;
        check("r0_write", r0, 32'hCAFEF00D);
        check_reads("r0_reads");

        // SP port
        drive_sp(32'h0000FFF0);
        tick();
        idle();
        #1;
        check("sp_r4", r4, 32'h0000FFF0);
        check("sp_rdsp", rdsp, 32'h0000FFF0);

        // Collision on the SP register: SP port wins
        drive_write(3'd4, 32'h12345678);
        drive_sp(32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("coll_r4", r4, 32'hDEADBEEF);
        check("coll_rdsp", rdsp, 32'hDEADBEEF);

        // Dual write to different registers
        drive_write(3'd7, 32'h77777777);
        drive_sp(32'h00001000);
        ra1 = 3'd7; ra2 = 3'd4;
        tick();
        idle();
        #1;
        check("dual_r7", r7, 32'h77777777);
        check("dual_r4", r4, 32'h00001000);
        check_reads("dual_reads");
        check_file("dual_file");

        // Reset overrides both write ports
        n_rst = 1'b1;
        drive_write(3'd2, 32'h22222222);
        drive_sp(32'h44444444);
        tick();
        n_rst = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 8; i++) check($sformatf("rst2_r%0d", i), get_r(i), 32'h0);
        check("rst2_rdsp", rdsp, 32'h0);
        check_reads("rst2_reads");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
